// File: rtl/kim_bus_arbiter.sv
// kim_bus_arbiter: shares the KIM-1 system bus between the 6502 CPU and a host
// debug/loader port. A host access stalls the CPU with RDY, borrows the bus for
// one cycle, hands it back and then restores RDY.
// Optional feature: define KIM_ARB_BURST_EN to let a held host_req chain up to
// MAX_BURST accesses under a single stall.
module kim_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        rdy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_ab,
  input  logic [7:0]  host_wd,
  output logic        host_ack,
  output logic [7:0]  host_rd,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_do,
  output logic        mem_we,
  input  logic [7:0]  mem_di,
  output logic        busy
);

  if ((MAX_BURST < 1) || (MAX_BURST > 4)) begin : gen_bad_burst
    $error("MAX_BURST must lie in 1..4");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStall,
    StAccess,
    StData,
    StRecover
  } state_e;

  state_e      state_q, state_d;
  logic        rdy_q;
  logic        ack_q;
  logic [7:0]  rd_q, rd_d;
  logic        burst_more;

`ifdef KIM_ARB_BURST_EN
  localparam logic [2:0] BurstLast = 3'(MAX_BURST - 1);

  logic [2:0] burst_q;

  assign burst_more = host_req && (burst_q < BurstLast);

  // Count chained re-accesses inside one grant; cleared once the CPU owns the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_q <= '0;
    end else if (state_q == StIdle) begin
      burst_q <= '0;
    end else if ((state_q == StData) && burst_more) begin
      burst_q <= burst_q + 3'd1;
    end
  end
`else
  assign burst_more = 1'b0;
`endif

  // Next-state logic. A grant is never taken while the CPU writes, because the
  // NMOS 6502 ignores RDY on write cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (host_req && !cpu_we) state_d = StStall;
      StStall:   state_d = StAccess;
      StAccess:  state_d = StData;
      StData:    state_d = burst_more ? StAccess : StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Read data arrives one cycle after the host address, i.e. in the ack cycle;
  // pass it straight through then and hold it in rd_q until the next read ack.
  always_comb begin
    rd_d = rd_q;
    if ((state_q == StData) && !host_we) rd_d = mem_di;
  end

  // State register plus registered RDY/ack, both decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rdy_q   <= 1'b1;
      ack_q   <= 1'b0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == StIdle);
      ack_q   <= (state_d == StData);
      rd_q    <= rd_d;
    end
  end

  // Bus mux: host drives only in the access cycle; the data cycle re-presents
  // the CPU address with writes suppressed.
  always_comb begin
    mem_ab = cpu_ab;
    mem_do = cpu_do;
    mem_we = cpu_we;
    unique case (state_q)
      StAccess: begin
        mem_ab = host_ab;
        mem_do = host_wd;
        mem_we = host_we;
      end
      StData:  mem_we = 1'b0;
      default: ;
    endcase
  end

  assign rdy      = rdy_q;
  assign host_ack = ack_q;
  assign host_rd  = rd_d;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_kim_bus_arbiter.sv
// Bench for kim_bus_arbiter: a KIM-1 memory map (RAM plus read-only ROM at
// 0x1800-0x1FFF) with registered reads, and a shadow memory as the reference.
module tb_kim_bus_arbiter;

`ifdef KIM_ARB_BURST_EN
  localparam int ExpGap         = 2;
  localparam int ExpRdyBetween  = 0;
`else
  localparam int ExpGap         = 5;
  localparam int ExpRdyBetween  = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab, host_ab, mem_ab;
  logic [7:0]  cpu_do, host_wd, host_rd, mem_do, mem_di;
  logic        cpu_we, host_req, host_we;
  logic        rdy, host_ack, mem_we, busy;

  logic [7:0]  mem    [65536];
  logic [7:0]  shadow [65536];
  bit          mem_ready;

  int checks   = 0;
  int failures = 0;

  kim_bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_ab   (cpu_ab),
    .cpu_do   (cpu_do),
    .cpu_we   (cpu_we),
    .rdy      (rdy),
    .host_req (host_req),
    .host_we  (host_we),
    .host_ab  (host_ab),
    .host_wd  (host_wd),
    .host_ack (host_ack),
    .host_rd  (host_rd),
    .mem_ab   (mem_ab),
    .mem_do   (mem_do),
    .mem_we   (mem_we),
    .mem_di   (mem_di),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 73) ^ (a >> 7) ^ 92);
  endfunction

  function automatic bit is_rom(input logic [15:0] a);
    return a[15:11] == 5'b00011;
  endfunction

  // System memory: ROM region ignores writes, reads are registered.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_we && !is_rom(mem_ab)) mem[mem_ab] <= mem_do;
      mem_di <= mem[mem_ab];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete host access, called at a negedge with the CPU reading.
  task automatic host_op(input bit we, input logic [15:0] ab, input logic [7:0] wd,
                         input string tag);
    int k, low, wcnt, lat, bad_busy;
    bit got;
    logic [7:0] exp_rd, rd;
    exp_rd = shadow[ab];
    host_we = we; host_ab = ab; host_wd = wd; host_req = 1'b1;
    k = 0; low = 0; wcnt = 0; lat = 0; bad_busy = 0; got = 1'b0; rd = '0;
    while (!got && k < 40) begin
      @(negedge clk); k++;
      if (!rdy) low++;
      if (busy !== !rdy) bad_busy++;
      if (mem_we) begin
        wcnt++;
        check({tag, " wr bus"}, {8'h00, mem_ab, mem_do}, {8'h00, ab, wd});
      end
      if (host_ack) begin
        got = 1'b1; lat = k; rd = host_rd; host_req = 1'b0;
      end
    end
    check({tag, " ack"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, 3);
    if (we) begin
      if (!is_rom(ab)) shadow[ab] = wd;
    end else begin
      check({tag, " rdata"}, 32'(rd), 32'(exp_rd));
    end
    check({tag, " we cycles"}, wcnt, 32'(we));
    while (!rdy && k < 60) begin
      @(negedge clk); k++;
      if (!rdy) low++;
      if (busy !== !rdy) bad_busy++;
    end
    check({tag, " stall cycles"}, low, 4);
    check({tag, " busy"}, bad_busy, 0);
    check({tag, " cpu fetch"}, 32'(mem_di), 32'(shadow[cpu_ab]));
  endtask

  task automatic cpu_read(input logic [15:0] a, input string tag);
    cpu_ab = a; cpu_we = 1'b0;
    @(negedge clk);
    check(tag, 32'(mem_di), 32'(shadow[a]));
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_ab = a; cpu_do = d; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    if (!is_rom(a)) shadow[a] = d;
  endtask

  // Three reads with host_req held throughout.
  task automatic host_multi3(input string tag);
    logic [15:0] addr [3];
    int acks, k, last_k;
    bit seen_rdy;
    for (int i = 0; i < 3; i++) addr[i] = 16'($urandom_range(0, 16'h03FF));
    host_we = 1'b0; host_ab = addr[0]; host_req = 1'b1;
    acks = 0; k = 0; last_k = 0; seen_rdy = 1'b0;
    while (acks < 3 && k < 80) begin
      @(negedge clk); k++;
      if (rdy && acks > 0) seen_rdy = 1'b1;
      if (host_ack) begin
        check({tag, " data"}, 32'(host_rd), 32'(shadow[addr[acks]]));
        if (acks > 0) begin
          check({tag, " gap"}, k - last_k, ExpGap);
          check({tag, " rdy between"}, 32'(seen_rdy), ExpRdyBetween);
        end
        last_k = k; seen_rdy = 1'b0; acks++;
        if (acks == 3) host_req = 1'b0;
        else host_ab = addr[acks];
      end
    end
    check({tag, " acks"}, acks, 3);
    k = 0;
    while (!rdy && k < 20) begin @(negedge clk); k++; end
    check({tag, " rdy back"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
    reset = 1'b0;
    cpu_ab = 16'h0300; cpu_do = 8'h00; cpu_we = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_ab = '0; host_wd = '0;
    repeat (3) @(negedge clk);
    check("reset rdy", 32'(rdy), 32'd1);
    check("reset ack", 32'(host_ack), 32'd0);
    check("reset host_rd", 32'(host_rd), 32'h00);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem mux", {7'd0, mem_we, mem_ab, mem_do}, {7'd0, cpu_we, cpu_ab, cpu_do});

    // Request rises together with reset release.
    reset = 1'b1;
    host_op(1'b0, 16'h0310, 8'h00, "rst release req");

    // RAM preloaded with 0x5A by the CPU, then read by the host.
    cpu_write(16'h0200, 8'h5A);
    cpu_ab = 16'h0300;
    host_op(1'b0, 16'h0200, 8'h00, "read 0200");
    check("read 0200 value", 32'(host_rd), 32'h5A);

    // Host write into RIOT RAM, then read back by the CPU.
    host_op(1'b1, 16'h1780, 8'hA5, "write 1780");
    cpu_read(16'h1780, "cpu sees 1780");

    // Host request while the CPU is writing: no stall until the write ends.
    cpu_ab = 16'h0250; cpu_do = 8'($urandom); cpu_we = 1'b1;
    host_we = 1'b0; host_ab = 16'h0200; host_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("cpu write rdy", 32'(rdy), 32'd1);
      check("cpu write bus", {7'd0, mem_we, mem_ab, mem_do}, {7'd0, 1'b1, cpu_ab, cpu_do});
    end
    shadow[16'h0250] = cpu_do;
    cpu_we = 1'b0;
    host_op(1'b0, 16'h0200, 8'h00, "after cpu write");
    cpu_read(16'h0250, "cpu write landed");

    // Held request across three accesses.
    cpu_ab = 16'h0300;
    host_multi3("multi");

    // Reset during the access cycle of a host write.
    host_we = 1'b1; host_ab = 16'h0280; host_wd = ~shadow[16'h0280]; host_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort in access", {15'd0, mem_we, mem_ab}, {15'd0, 1'b1, 16'h0280});
    reset = 1'b0;
    #1;
    check("abort rdy", 32'(rdy), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort ack", 32'(host_ack), 32'd0);
    check("abort mem_we", 32'(mem_we), 32'd0);
    check("abort host_rd", 32'(host_rd), 32'h00);
    host_req = 1'b0;
    acks = 0;
    @(negedge clk);
    if (host_ack) acks++;
    @(negedge clk);
    if (host_ack) acks++;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (host_ack) acks++;
    end
    check("abort no ack", acks, 0);
    cpu_read(16'h0280, "abort mem kept");

    // ROM byte at offset 0x400.
    cpu_ab = 16'h0300;
    host_op(1'b0, 16'h1C00, 8'h00, "rom read");
    check("rom 1C00", 32'(host_rd), 32'(init_val(32'h1C00)));

    // Randomised accesses against the shadow memory.
    for (int n = 0; n < 20; n++) begin
      bit          w;
      logic [15:0] a;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a = 16'($urandom_range(0, 16'h03FF));
        1:       a = 16'($urandom_range(16'h1780, 16'h17FF));
        default: a = w ? 16'($urandom_range(0, 16'h03FF))
                       : 16'($urandom_range(16'h1800, 16'h1FFF));
      endcase
      cpu_ab = 16'($urandom_range(0, 16'h03FF));
      cpu_we = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      host_op(w, a, 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
